// File: rtl/divider_sequencer_if.sv
// rtl/divider_sequencer_if.sv - operand/result streams and divider port bundle
interface divider_sequencer_if #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_r;
  logic             out_dbz;
  logic             out_tmo;
  logic [CW-1:0]    count;
  logic             div_start;
  logic [WIDTH-1:0] div_x;
  logic [WIDTH-1:0] div_y;
  logic             div_busy;
  logic             div_val;
  logic             div_dbz;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;

  // Sequencer side
  modport slave (
    input  in_valid, in_x, in_y, out_ready,
           div_busy, div_val, div_dbz, div_q, div_r,
    output in_ready, out_valid, out_q, out_r, out_dbz, out_tmo, count,
           div_start, div_x, div_y
  );

  // Producer/consumer/divider side
  modport master (
    output in_valid, in_x, in_y, out_ready,
           div_busy, div_val, div_dbz, div_q, div_r,
    input  in_ready, out_valid, out_q, out_r, out_dbz, out_tmo, count,
           div_start, div_x, div_y
  );
endinterface

// File: rtl/divider_sequencer.sv
// rtl/divider_sequencer.sv - operand FIFO and issue/collect sequencer for the iterative divider
module divider_sequencer #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int TMO   = WIDTH + 4
) (
  input  logic clk,
  input  logic rst,
  divider_sequencer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TMO + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t                 state_q;
  logic [2*WIDTH-1:0]     mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q;
  logic [AW-1:0]          rd_ptr_q;
  logic [CW-1:0]          count_q;
  logic [CW-1:0]          count_d;
  logic                   div_start_q;
  logic [WIDTH-1:0]       div_x_q;
  logic [WIDTH-1:0]       div_y_q;
  logic                   out_valid_q;
  logic [WIDTH-1:0]       out_q_q;
  logic [WIDTH-1:0]       out_r_q;
  logic                   out_dbz_q;
  logic                   out_tmo_q;
  logic                   seen_busy_q;
  logic [TW-1:0]          tmo_cnt_q;
  logic                   in_ready;
  logic                   push;
  logic                   pop;
  logic [2*WIDTH-1:0]     head;

  // A full FIFO deasserts in_ready, so push+pop never happens when full.
  assign in_ready = (count_q < DEPTH_C);
  assign push     = bus.in_valid & in_ready;
  assign pop      = (state_q == IDLE) && (count_q != '0) && !bus.div_busy;
  assign head     = mem_q[rd_ptr_q];

  assign bus.in_ready  = in_ready;
  assign bus.count     = count_q;
  assign bus.div_start = div_start_q;
  assign bus.div_x     = div_x_q;
  assign bus.div_y     = div_y_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_q     = out_q_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_dbz   = out_dbz_q;
  assign bus.out_tmo   = out_tmo_q;

  // Occupancy next-state: simultaneous push and pop cancel out
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Operand storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.in_x, bus.in_y};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Issue/collect FSM with registered divider and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      div_start_q <= 1'b0;
      div_x_q     <= '0;
      div_y_q     <= '0;
      out_valid_q <= 1'b0;
      out_q_q     <= '0;
      out_r_q     <= '0;
      out_dbz_q   <= 1'b0;
      out_tmo_q   <= 1'b0;
      seen_busy_q <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Divider may still be busy from an op abandoned by reset
          if (pop) begin
            div_x_q     <= head[2*WIDTH-1:WIDTH];
            div_y_q     <= head[WIDTH-1:0];
            div_start_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          div_start_q <= 1'b0;
          seen_busy_q <= 1'b0;
          tmo_cnt_q   <= '0;
          state_q     <= WAIT;
        end
        WAIT: begin
          // div_val only counts once this op has made the divider busy
          seen_busy_q <= seen_busy_q | bus.div_busy;
          if (bus.div_dbz) begin
            out_q_q     <= '0;
            out_r_q     <= '0;
            out_dbz_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else if (seen_busy_q && bus.div_val && !bus.div_busy) begin
            out_q_q     <= bus.div_q;
            out_r_q     <= bus.div_r;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else if (tmo_cnt_q == TMO_LAST) begin
            out_q_q     <= '0;
            out_r_q     <= '0;
            out_tmo_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_dbz_q   <= 1'b0;
            out_tmo_q   <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider_sequencer.sv
// tb/tb_divider_sequencer.sv - directed self-checking bench for divider_sequencer
module tb_divider_sequencer;
  localparam int W     = 6;
  localparam int D     = 4;
  localparam int TMO   = W + 4;
  localparam int LIMIT = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  divider_sequencer_if #(.WIDTH(W), .DEPTH(D)) bus ();

  divider_sequencer #(.WIDTH(W), .DEPTH(D), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Divider stub: busy for W cycles, then q/r with val held until the next start
  logic         stub_busy = 1'b0;
  logic         stub_val  = 1'b0;
  logic         stub_dbz  = 1'b0;
  logic [W-1:0] stub_q    = '0;
  logic [W-1:0] stub_r    = '0;
  int           stub_cnt  = 0;
  logic         stub_en    = 1'b1;
  logic         force_busy = 1'b0;
  logic         force_val  = 1'b0;

  assign bus.div_busy = stub_busy | force_busy;
  assign bus.div_val  = stub_val | force_val;
  assign bus.div_dbz  = stub_dbz;
  assign bus.div_q    = stub_q;
  assign bus.div_r    = stub_r;

  always @(posedge clk) begin
    if (stub_en && bus.div_start) begin
      stub_val <= 1'b0;
      if (bus.div_y == '0) begin
        stub_dbz  <= 1'b1;
        stub_busy <= 1'b0;
      end else begin
        stub_dbz  <= 1'b0;
        stub_busy <= 1'b1;
        stub_cnt  <= W - 1;
        stub_q    <= bus.div_x / bus.div_y;
        stub_r    <= bus.div_x % bus.div_y;
      end
    end else if (stub_busy) begin
      if (stub_cnt == 0) begin
        stub_busy <= 1'b0;
        stub_val  <= 1'b1;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called and returns at a negedge; holds in_valid until accepted
  task automatic push(input int x, input int y);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_x = W'(x);
    bus.in_y = W'(y);
    while (!bus.in_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (n >= LIMIT) check("push_accept_timeout", 32'(n), 32'(0));
  endtask

  task automatic wait_start(input string tag, output int n);
    n = 0;
    while (!bus.div_start && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start_seen"}, 32'(bus.div_start), 32'(1));
  endtask

  task automatic get_result(input string tag, input int q, input int r, input int dbz, input int tmo);
    int n;
    n = 0;
    while (!bus.out_valid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(1));
    check({tag, "_q"}, 32'(bus.out_q), 32'(q));
    check({tag, "_r"}, 32'(bus.out_r), 32'(r));
    check({tag, "_dbz"}, 32'(bus.out_dbz), 32'(dbz));
    check({tag, "_tmo"}, 32'(bus.out_tmo), 32'(tmo));
    @(negedge clk);
  endtask

  initial begin
    int n;
    int starts;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_count", 32'(bus.count), 32'(0));
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_div_start", 32'(bus.div_start), 32'(0));
    check("rst_div_x", 32'(bus.div_x), 32'(0));
    check("rst_out_q", 32'(bus.out_q), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));

    // 1: single op, one-cycle start, result, valid drops after handshake
    push(11, 3);
    wait_start("t1", n);
    check("t1_start_lat", 32'(n), 32'(1));
    check("t1_div_x", 32'(bus.div_x), 32'(11));
    check("t1_div_y", 32'(bus.div_y), 32'(3));
    @(negedge clk);
    check("t1_start_pulse", 32'(bus.div_start), 32'(0));
    get_result("t1", 3, 2, 0, 0);
    check("t1_valid_drop", 32'(bus.out_valid), 32'(0));

    // 2: divide-by-zero then normal op
    push(10, 0);
    get_result("t2a", 0, 0, 1, 0);
    push(63, 8);
    get_result("t2b", 7, 7, 0, 0);

    // 3: backpressure fills the FIFO; results drain in push order
    bus.out_ready = 1'b0;
    push(13, 4);
    push(50, 7);
    push(9, 9);
    push(5, 6);
    push(62, 3);
    check("t3_count_full", 32'(bus.count), 32'(4));
    check("t3_in_ready_full", 32'(bus.in_ready), 32'(0));
    bus.out_ready = 1'b1;
    get_result("t3a", 3, 1, 0, 0);
    get_result("t3b", 7, 1, 0, 0);
    get_result("t3c", 1, 0, 0, 0);
    get_result("t3d", 0, 5, 0, 0);
    get_result("t3e", 20, 2, 0, 0);
    check("t3_count_drained", 32'(bus.count), 32'(0));

    // 4a: divider stuck busy -> timeout TMO cycles after ISSUE
    stub_en = 1'b0;
    force_busy = 1'b1;
    push(20, 4);
    // IDLE must not issue while busy
    repeat (3) @(negedge clk);
    check("t4a_no_issue_busy", 32'(bus.count), 32'(1));
    force_busy = 1'b0;
    wait_start("t4a", n);
    force_busy = 1'b1;
    n = 0;
    while (!bus.out_valid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("t4a_tmo_lat", 32'(n), 32'(TMO + 1));
    get_result("t4a", 0, 0, 0, 1);
    force_busy = 1'b0;

    // 4b: stale val with busy low is never taken as a result
    force_val = 1'b1;
    push(21, 5);
    get_result("t4b", 0, 0, 0, 1);
    force_val = 1'b0;
    stub_en = 1'b1;

    // 5: reset during WAIT with two entries queued
    push(40, 5);
    push(30, 4);
    push(20, 3);
    check("t5_pre_count", 32'(bus.count), 32'(2));
    rst = 1'b1;
    #1;
    check("t5_rst_count", 32'(bus.count), 32'(0));
    check("t5_rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("t5_rst_div_start", 32'(bus.div_start), 32'(0));
    force_busy = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push(50, 5);
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.div_start) starts++;
      @(negedge clk);
    end
    check("t5_no_start_busy", 32'(starts), 32'(0));
    check("t5_count_held", 32'(bus.count), 32'(1));
    force_busy = 1'b0;
    wait_start("t5", n);
    check("t5_div_x", 32'(bus.div_x), 32'(50));
    get_result("t5", 10, 0, 0, 0);

    // 6: push in the same cycle as the issue pop with count=2
    bus.out_ready = 1'b0;
    push(17, 5);
    push(33, 2);
    push(8, 0);
    n = 0;
    while (!bus.out_valid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("t6a_q", 32'(bus.out_q), 32'(3));
    check("t6a_r", 32'(bus.out_r), 32'(2));
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t6_count_before", 32'(bus.count), 32'(2));
    bus.in_valid = 1'b1;
    bus.in_x = W'(45);
    bus.in_y = W'(6);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("t6_count_pushpop", 32'(bus.count), 32'(2));
    check("t6_start", 32'(bus.div_start), 32'(1));
    get_result("t6b", 16, 1, 0, 0);
    get_result("t6c", 0, 0, 1, 0);
    get_result("t6d", 7, 3, 0, 0);
    check("t6_count_end", 32'(bus.count), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
